pc_gen: RTL and testbench

//   Parametrised program-counter generator for the NPC front end: holds the fetch PC and offers it
//   to the fetch stage over a valid/ready handshake. Advances sequentially on each accepted PC and

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen.sv | 103 ++++++++++
 tb/tb_pc_gen.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the NPC front-end program-counter generator.
// Holds the state encoding of pc_gen and the default reset vector.
package pc_gen_pkg;

  // Fetch-PC generator states.
  typedef enum logic [1:0] {
    PcgBoot = 2'd0,
    PcgRun  = 2'd1,
    PcgHalt = 2'd2
  } pcg_state_e;

  // Default PC presented after reset.
  localparam logic [31:0] PcgResetVec = 32'h8000_0000;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator for the NPC front end.
// Holds the fetch PC and offers it to fetch over a valid/ready handshake.
// The PC advances by INST_BYTES on each accepted PC. Redirects are prioritised, with trap
// first and branch second. Each redirect bumps an epoch tag so downstream can drop stale
// fetches. The block supports halt/resume and flags misaligned PCs.
// All outputs are registered; no input reaches an output combinationally.
//
// Ports:
//   clk           clock, posedge
//   rst           synchronous active-high reset
//   pc_valid_o    pc_o/epoch_o/misalign_o valid to fetch
//   pc_ready_i    fetch accepts the PC this cycle
//   pc_o          current fetch PC
//   epoch_o       epoch tag of pc_o
//   misalign_o    pc_o not a multiple of INST_BYTES
//   br_valid_i    branch/jump redirect request
//   br_target_i   branch target
//   trap_valid_i  trap/mret redirect request (wins over branch)
//   trap_target_i trap vector / return address
//   halt_i        level halt request
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PcgResetVec),
  parameter int unsigned     INST_BYTES = 4,
  parameter int unsigned     EPOCH_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pc_valid_o,
  input  logic               pc_ready_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               misalign_o,
  input  logic               br_valid_i,
  input  logic [XLEN-1:0]    br_target_i,
  input  logic               trap_valid_i,
  input  logic [XLEN-1:0]    trap_target_i,
  input  logic               halt_i
);

  localparam logic [XLEN-1:0] AlignMask = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] PcIncr    = XLEN'(INST_BYTES);

  pcg_state_e         state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               misalign_q, misalign_d;
  logic               fire;

  assign pc_valid_o = (state_q == PcgRun);
  assign fire       = pc_valid_o & pc_ready_i;

  // State: BOOT lasts one cycle after reset. Redirects never change the state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PcgBoot: state_d = halt_i ? PcgHalt : PcgRun;
      PcgRun:  state_d = halt_i ? PcgHalt : PcgRun;
      PcgHalt: state_d = halt_i ? PcgHalt : PcgRun;
      default: state_d = PcgBoot;
    endcase
  end

  // Next-PC priority chain: trap > branch > sequential fire > hold.
  // A redirect beats a same-cycle fire. The fired PC keeps the old epoch and is dropped
  // downstream.
  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (trap_valid_i) begin
      pc_d    = trap_target_i;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (br_valid_i) begin
      pc_d    = br_target_i;
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (fire) begin
      pc_d = pc_q + PcIncr;
    end
    // A sequential increment preserves alignment, so one expression covers every case.
    misalign_d = |(pc_d & AlignMask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PcgBoot;
      pc_q       <= RESET_VEC;
      epoch_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign epoch_o    = epoch_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen.
// Each table row gives the inputs for one cycle and the outputs expected in the cycle after.
// Expected outputs are queued when a row is driven. They are popped and compared one cycle
// later, away from the clock edge.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        pc_valid_o;
  logic        pc_ready_i;
  logic [31:0] pc_o;
  logic [1:0]  epoch_o;
  logic        misalign_o;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        trap_valid_i;
  logic [31:0] trap_target_i;
  logic        halt_i;

  pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .pc_valid_o   (pc_valid_o),
    .pc_ready_i   (pc_ready_i),
    .pc_o         (pc_o),
    .epoch_o      (epoch_o),
    .misalign_o   (misalign_o),
    .br_valid_i   (br_valid_i),
    .br_target_i  (br_target_i),
    .trap_valid_i (trap_valid_i),
    .trap_target_i(trap_target_i),
    .halt_i       (halt_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  epoch;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        brv;
    logic [31:0] brt;
    logic        trv;
    logic [31:0] trt;
    logic        halt;
    exp_t        exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic r, input logic rdy, input logic brv, input logic [31:0] brt,
                     input logic trv, input logic [31:0] trt, input logic halt,
                     input logic ev, input logic [31:0] epc, input logic [1:0] eep,
                     input logic emis);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.brv = brv; v.brt = brt; v.trv = trv; v.trt = trt;
    v.halt = halt;
    v.exp.valid = ev; v.exp.pc = epc; v.exp.epoch = eep; v.exp.mis = emis;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    exp_t act;
    e = sb.pop_front();
    act.valid = pc_valid_o; act.pc = pc_o; act.epoch = epoch_o; act.mis = misalign_o;
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b pc=%08h epoch=%0d mis=%0b, want valid=%0b pc=%08h epoch=%0d mis=%0b",
               name, act.valid, act.pc, act.epoch, act.mis, e.valid, e.pc, e.epoch, e.mis);
    end
  endtask

  initial begin
    //  rst rdy brv brt           trv trt           halt  valid pc            ep mis
    // Reset, then boot bubble and sequential fetch.
    add(1, 1, 0, 32'h0,         0, 32'h0,         0,    0, 32'h8000_0000, 0, 0);
    add(1, 1, 0, 32'h0,         0, 32'h0,         0,    0, 32'h8000_0000, 0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0000, 0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0004, 0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0008, 0, 0);
    // Backpressure holds the PC.
    add(0, 0, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0008, 0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0008, 0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0008, 0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_000C, 0, 0);
    // Trap beats a same-cycle branch and fire.
    add(0, 1, 1, 32'h8000_0100, 1, 32'h8000_0200, 0,    1, 32'h8000_0200, 1, 0);
    // Misaligned branch target; the flag survives a sequential increment.
    add(0, 1, 1, 32'h8000_0102, 0, 32'h0,         0,    1, 32'h8000_0102, 2, 1);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0106, 2, 1);
    add(0, 1, 1, 32'h8000_0200, 0, 32'h0,         0,    1, 32'h8000_0200, 3, 0);
    // Halt for four cycles. The first PC still fires. A branch lands mid-halt and wraps
    // the epoch from 3 to 0.
    add(0, 1, 0, 32'h0,         0, 32'h0,         1,    0, 32'h8000_0204, 3, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         1,    0, 32'h8000_0204, 3, 0);
    add(0, 1, 1, 32'h8000_0040, 0, 32'h0,         1,    0, 32'h8000_0040, 0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         1,    0, 32'h8000_0040, 0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0040, 0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0044, 0, 0);
    // The PC wraps modulo 2**32.
    add(0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0,    1, 32'hFFFF_FFFC, 1, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,         0,    1, 32'hFFFF_FFFC, 1, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h0000_0000, 1, 0);
    // Four redirects wrap the epoch again.
    add(0, 1, 1, 32'h0000_0010, 0, 32'h0,         0,    1, 32'h0000_0010, 2, 0);
    add(0, 0, 0, 32'h0,         1, 32'h0000_0020, 0,    1, 32'h0000_0020, 3, 0);
    add(0, 1, 1, 32'h0000_0030, 0, 32'h0,         0,    1, 32'h0000_0030, 0, 0);
    add(0, 1, 1, 32'h0000_0042, 0, 32'h0,         0,    1, 32'h0000_0042, 1, 1);
    // Mid-run reset drops a pending branch and clears everything.
    add(1, 1, 1, 32'h0000_0100, 0, 32'h0,         0,    0, 32'h8000_0000, 0, 0);
    // A trap taken during BOOT with halt high: the redirect applies and the state goes to HALT.
    add(0, 1, 0, 32'h0,         1, 32'h8000_0300, 1,    0, 32'h8000_0300, 1, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0300, 1, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,         0,    1, 32'h8000_0304, 1, 0);

    rst = 1'b1; pc_ready_i = 1'b0; br_valid_i = 1'b0; br_target_i = '0;
    trap_valid_i = 1'b0; trap_target_i = '0; halt_i = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (sb.size() != 0) check_out($sformatf("row%0d", i - 1));
      rst           = vecs[i].rst;
      pc_ready_i    = vecs[i].rdy;
      br_valid_i    = vecs[i].brv;
      br_target_i   = vecs[i].brt;
      trap_valid_i  = vecs[i].trv;
      trap_target_i = vecs[i].trt;
      halt_i        = vecs[i].halt;
      sb.push_back(vecs[i].exp);
    end
    @(negedge clk);
    check_out($sformatf("row%0d", vecs.size() - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
